// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction-memory responder
//
// Purpose: common width, the NOP substituted on faulting fetches, and the
//          response record carried through the latency pipe and response FIFO.
// Ports:   none (package)
package imem_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] addr;
    logic            fault;
  } resp_t;

endpackage

// File: rtl/imem_resp_fifo.sv
// rtl/imem_resp_fifo.sv - synchronous response FIFO of resp_t with flush clear
//
// Purpose: buffers completed fetch responses while decode stalls.
// Ports:   clock, reset (sync, active-low), clear (drops all entries),
//          push/wr_data (enqueue), pop (dequeue head), rd_data (head entry),
//          full, empty, count (entries held, 0..DEPTH).
module imem_resp_fifo
  import imem_pkg::*;
#(
  parameter int DEPTH = 3,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  resp_t         wr_data,
  input  logic          pop,
  output resp_t         rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  resp_t         store [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = store[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) store[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction-memory responder on the fetch interface
//
// Purpose: accepts word fetches, reads the instruction RAM, and returns
//          responses in order after LATENCY cycles; supports redirect flush,
//          decode backpressure and a program-load write port.
// Ports:   clock, reset (sync, active-low)
//          req_valid/req_ready/req_addr        fetch request
//          flush                               drop everything in flight
//          resp_valid/resp_ready/resp_instr/resp_addr/resp_fault  response
//          load_en/load_addr/load_data         program-load write
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int OUT_DEPTH   = LATENCY + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_instr,
  output logic [XLEN-1:0] resp_addr,
  output logic            resp_fault,
  input  logic            load_en,
  input  logic [XLEN-1:0] load_addr,
  input  logic [XLEN-1:0] load_data
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(OUT_DEPTH + 1);

  logic [XLEN-1:0] ram [DEPTH_WORDS];
  logic [XLEN-1:0] rd_data;
  logic [AW-1:0]   req_idx;
  logic [AW-1:0]   load_idx;
  logic            req_fault;
  logic            load_ok;
  logic            accept;
  logic            unused_load_bits;

  resp_t              pipe_q [LATENCY];
  logic [LATENCY-1:0] pipe_v;
  resp_t              stage  [LATENCY];
  resp_t              tail;
  logic               tail_v;

  resp_t         fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          fifo_push;
  logic          fifo_pop;
  logic [CW-1:0] outstanding;
  resp_t         resp_sel;

  assign req_idx   = req_addr[AW+1:2];
  assign req_fault = (req_addr[1:0] != 2'b00) || (req_addr[XLEN-1:AW+2] != '0);
  assign load_idx  = load_addr[AW+1:2];
  assign load_ok   = load_en && (load_addr[XLEN-1:AW+2] == '0);
  assign unused_load_bits = ^load_addr[1:0];
  assign accept    = req_valid && req_ready;

  // Write and read share the edge; the nonblocking write makes a same-word
  // read in the accept cycle return the old word.
  always_ff @(posedge clock) begin
    if (load_ok) ram[load_idx] <= load_data;
    rd_data <= ram[req_idx];
  end

  // Stage 0 holds the request; its instruction is the RAM output register.
  always_comb begin
    for (int i = 0; i < LATENCY; i++) stage[i] = pipe_q[i];
    stage[0].instr = pipe_q[0].fault ? NOP_INSTR : rd_data;
  end

  always_ff @(posedge clock) begin
    pipe_q[0] <= '{instr: '0, addr: req_addr, fault: req_fault};
    for (int i = 1; i < LATENCY; i++) pipe_q[i] <= stage[i-1];
  end

  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= accept;
      for (int i = 1; i < LATENCY; i++) pipe_v[i] <= pipe_v[i-1];
    end
  end

  assign tail   = stage[LATENCY-1];
  assign tail_v = pipe_v[LATENCY-1];

  // The pipe never stalls: outstanding is capped at the FIFO depth, so the
  // tail can always be pushed. With an empty FIFO the tail is presented
  // directly and only buffered if it is not taken this cycle.
  assign fifo_push = tail_v && !(fifo_empty && resp_ready) && !fifo_full;
  assign fifo_pop  = resp_ready && !fifo_empty;

  imem_resp_fifo #(.DEPTH(OUT_DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .clear   (flush),
    .push    (fifo_push),
    .wr_data (tail),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Outstanding is a function of registered state only, keeping resp_ready
  // out of the req_ready path.
  always_comb begin
    outstanding = fifo_count;
    for (int i = 0; i < LATENCY; i++) outstanding = outstanding + CW'(pipe_v[i]);
  end

  assign req_ready  = (outstanding < CW'(OUT_DEPTH)) && !flush;

  assign resp_valid = tail_v || !fifo_empty;
  assign resp_sel   = fifo_empty ? tail : fifo_head;
  assign resp_instr = resp_valid ? resp_sel.instr : '0;
  assign resp_addr  = resp_valid ? resp_sel.addr  : '0;
  assign resp_fault = resp_valid && resp_sel.fault;

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the memory side of the fetch interface.
- Accepts word-fetch requests from the fetch stage and returns instructions in order after a fixed read latency.
- Supports branch-redirect flush, downstream backpressure (decode stall), and a program-load write port for the boot loader and testbench.
- Sits between the fetch PC logic and the on-chip instruction RAM.

Parameters:
DEPTH_WORDS, 1024, instruction RAM size in 32-bit words (power of two, 16..65536)
LATENCY, 2, request-accept to resp_valid delay in cycles (1..4)
OUT_DEPTH, LATENCY+1, max outstanding requests (in pipe plus in response FIFO)

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
req_valid  input  1  fetch request valid
req_ready  output  1  responder can accept a request this cycle
req_addr  input  32  byte address of instruction
flush  input  1  redirect (PCSrcE); cancels all in-flight and buffered responses
resp_valid  output  1  response valid
resp_ready  input  1  consumer accepts response (low = decode stall)
resp_instr  output  32  instruction word
resp_addr  output  32  byte address the response belongs to
resp_fault  output  1  misaligned or out-of-range fetch
load_en  input  1  program-load write strobe
load_addr  input  32  byte address for load (bits [1:0] ignored)
load_data  input  32  word to write

Behaviour:
- Reset is synchronous: sampled on the clock edge while reset=0.
  - resp_valid=0, resp_instr=0, resp_addr=0, resp_fault=0.
  - Pipeline valids and FIFO pointers/count cleared; req_ready=1 from the first cycle after reset deasserts.
  - RAM contents are not reset.
- Reset mid-operation discards all outstanding requests; no responses are produced for them.
- Accept occurs when req_valid && req_ready. RAM is read at accept using word index req_addr[log2(DEPTH_WORDS)+1:2].
- Latency: a request accepted in cycle N presents resp_valid in cycle N+LATENCY, provided the FIFO is empty and not blocked.
- Responses are strictly in order; the response is consumed when resp_valid && resp_ready.
- Outstanding count = requests in the LATENCY-stage pipe plus entries in the response FIFO, with 0..OUT_DEPTH valid.
  - req_ready = (count < OUT_DEPTH) && !flush. It is registered/derived from state only; there is no combinational path from resp_ready.
  - Count is incremented on accept, decremented on response handshake; simultaneous accept and handshake leaves it unchanged.
- Backpressure: while resp_ready=0, resp_valid/instr/addr/fault hold stable. Pipe stages advance into the FIFO; the FIFO absorbs up to OUT_DEPTH entries and never overflows.
- Flush:
  - In the cycle flush=1, all pipe valids and FIFO entries are cleared and count becomes 0.
  - A req_valid in the flush cycle is not accepted.
  - resp_valid=0 from the next cycle.
  - A response handshake coinciding with flush completes normally; the consumer discards it.
  - A request accepted in the cycle after flush responds normally.
- Faults:
  - req_addr[1:0]!=0, or word index >= DEPTH_WORDS (any higher address bit set), gives resp_fault=1 and resp_instr=32'h00000013 (NOP).
  - Faulted requests take the same latency and ordering as normal ones.
- Load port:
  - Write commits at the clock edge when load_en=1.
  - A read accepted in the same cycle to the same word returns the old data (read-before-write); from the next cycle the new data is returned.
  - Out-of-range load addresses are ignored.
  - Load does not affect req_ready.
- Widths: count is $clog2(OUT_DEPTH+1) bits; FIFO pointers wrap modulo OUT_DEPTH.

Decomposition:
- Shared package imem_pkg:
  - NOP_INSTR = 32'h00000013
  - XLEN = 32
  - struct resp_t {instr, addr, fault}
- One sub-module: imem_resp_fifo, a synchronous FIFO of resp_t, depth OUT_DEPTH, with clear input driven by flush, full/empty/count outputs.
- The RAM array and latency pipe stay in imem_responder.

Test Plan:
- Reset and sequential fetch:
  - Stimulus: load words 0x00500093 @0x0, 0x00A00113 @0x4, 0x002081B3 @0x8; deassert reset; request 0x0, 0x4, 0x8 back-to-back with resp_ready=1.
  - Required response: resp_valid in cycles N+2..N+4 with those instrs/addrs in order, fault=0, req_ready stays 1.
- Backpressure:
  - Stimulus: resp_ready=0 while issuing 4 requests.
  - Required response: exactly 3 (OUT_DEPTH) accepted, req_ready=0 afterwards, resp_valid held stable with the first instr.
  - Stimulus: raise resp_ready.
  - Required response: 3 responses drain in order, then req_ready returns to 1.
- Flush:
  - Stimulus: 2 requests in flight (0x10, 0x14); assert flush with req_valid=1 at 0x40.
  - Required response: no responses for 0x10, 0x14, 0x40; a next-cycle request for 0x40 responds after 2 cycles.
- Fault:
  - Stimulus: request 0x2, then 0x00001000 (DEPTH_WORDS=1024).
  - Required response: both give resp_fault=1 and resp_instr=0x00000013, in order, latency 2.
- Load/read collision:
  - Stimulus: word @0x8 = 0xAAAAAAAA; same cycle load 0xBBBBBBBB @0x8 and request 0x8; next-cycle request 0x8.
  - Required response: first read returns 0xAAAAAAAA, second returns 0xBBBBBBBB.
- Mid-operation reset:
  - Stimulus: 3 outstanding with resp_ready=0; pulse reset=0 for one cycle.
  - Required response: resp_valid=0 and req_ready=1 afterwards, and no stale responses emerge.
